// File: rtl/mak8_pkg.sv
// Shared MAK-8 definitions.
// Used by the ALU and by alu_sequencer:
//   alu_op_t    - ALU operation select (ADD = 0 .. SHR = 7)
//   CMD_MUL     - command code for the 8x8->16 unsigned multiply
//   CMD_SINGLE  - value of cmd_code[3] that marks a single ALU op (0_ooo)
//   seq_state_t - alu_sequencer controller states
package mak8_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_t;

    localparam logic [3:0] CMD_MUL    = 4'b1000;
    localparam logic       CMD_SINGLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_STEP = 2'd2,
        DONE     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller between the MAK-8 execute stage and
// the shared 8-bit ALU (the ALU itself lives in the parent).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low. cmd_ready is high only in IDLE (and low during rst or
// flush); res_valid is high only in DONE.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_code, cmd_a, cmd_b payload
//   flush               synchronous abort of the in-flight command
//   res_valid/ready     result handshake; res_hi, res_lo, res_err payload
//   flag_z/c/n          persistent flag register
//   alu_a/b/op          drive to the shared ALU (0 outside EXEC / MUL_STEP)
//   alu_result/zero/carry/negative  ALU response
//   state_dbg           current controller state (seq_state_t encoding)
module alu_sequencer
    import mak8_pkg::*;
#(
    parameter int SUPPORT_MUL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_code,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       flush,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_hi,
    output logic [7:0] res_lo,
    output logic       res_err,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_n,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_negative,
    output logic [1:0] state_dbg
);

    seq_state_t state;
    seq_state_t state_next;

    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [3:0] code_r;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] mcand;
    logic [2:0] cnt;

    logic       accept;
    logic       cmd_is_mul;
    logic       code_is_single;
    logic       mul_last;
    logic [7:0] step_hi;
    logic [7:0] step_lo;

    // Held low while rst is asserted so nothing is offered before release.
    assign cmd_ready      = (state == IDLE) && !rst && !flush;
    assign accept         = cmd_valid && cmd_ready;
    assign cmd_is_mul     = (SUPPORT_MUL != 0) && (cmd_code == CMD_MUL);
    assign code_is_single = (code_r[3] == CMD_SINGLE);
    assign mul_last       = (cnt == 3'd7);
    assign res_valid      = (state == DONE);
    assign state_dbg      = state;

    // One shift-add step: {carry, sum} shifted right into the hi:lo pair.
    // The multiplier bits leave lo from the bottom as product bits enter
    // from the top.
    assign step_hi = {alu_carry, alu_result[7:1]};
    assign step_lo = {alu_result[0], lo[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_op     = OP_ADD;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = cmd_is_mul ? MUL_STEP : EXEC;
                end
            end
            EXEC: begin
                // Reserved codes leave the ALU inputs at 0.
                if (code_is_single) begin
                    alu_op = code_r[2:0];
                    alu_a  = a_r;
                    alu_b  = b_r;
                end
                state_next = DONE;
            end
            MUL_STEP: begin
                alu_op = OP_ADD;
                alu_a  = hi;
                alu_b  = lo[0] ? mcand : 8'h00;
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // flush wins over every other transition, including res_ready.
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Datapath. Result and flag registers only load on the transition into
    // DONE, so a flushed command never disturbs them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            code_r  <= 4'h0;
            hi      <= 8'h00;
            lo      <= 8'h00;
            mcand   <= 8'h00;
            cnt     <= 3'd0;
            res_hi  <= 8'h00;
            res_lo  <= 8'h00;
            res_err <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r    <= cmd_a;
                        b_r    <= cmd_b;
                        code_r <= cmd_code;
                        hi     <= 8'h00;
                        lo     <= cmd_b;
                        mcand  <= cmd_a;
                        cnt    <= 3'd0;
                    end
                end
                EXEC: begin
                    if (!flush) begin
                        res_hi <= 8'h00;
                        if (code_is_single) begin
                            res_lo  <= alu_result;
                            res_err <= 1'b0;
                            flag_z  <= alu_zero;
                            flag_c  <= alu_carry;
                            flag_n  <= alu_negative;
                        end else begin
                            res_lo  <= 8'h00;
                            res_err <= 1'b1;
                        end
                    end
                end
                MUL_STEP: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 3'd1;
                    if (mul_last && !flush) begin
                        res_hi  <= step_hi;
                        res_lo  <= step_lo;
                        res_err <= 1'b0;
                        flag_z  <= ({step_hi, step_lo} == 16'h0000);
                        flag_c  <= (step_hi != 8'h00);
                        flag_n  <= step_hi[7];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sits between the MAK-8 execute stage and the shared 8-bit ALU. It accepts commands over a valid/ready handshake and drives the ALU's a/b/op inputs. Single ALU ops complete in one execute cycle. An 8x8->16 unsigned multiply is run as an 8-step shift-add loop on the ALU's ADD operation. Results and a persistent Z/C/N flag register are returned over a valid/ready handshake.

Parameters:
SUPPORT_MUL, 1, when 0 the MUL encoding is handled as a reserved command

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  reset, asynchronous and active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command (IDLE only)
cmd_code  input  4  0_ooo = single ALU op ooo; 1_000 = MUL; other 1_xxx codes are reserved
cmd_a  input  8  operand A / multiplicand
cmd_b  input  8  operand B / multiplier
flush  input  1  synchronous abort; in-flight command is discarded
res_valid  output  1  result available
res_ready  input  1  result consumer accepts
res_hi  output  8  product high byte (0 for single ops)
res_lo  output  8  result / product low byte
res_err  output  1  reserved command flag
flag_z  output  1  persistent zero flag
flag_c  output  1  persistent carry/borrow flag
flag_n  output  1  persistent negative flag
alu_a  output  8  to ALU operand a
alu_b  output  8  to ALU operand b
alu_op  output  3  to ALU op select
alu_result  input  8  from ALU
alu_zero  input  1  from ALU
alu_carry  input  1  from ALU
alu_negative  input  1  from ALU

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE.
  - All registers cleared; res_* = 0 and flags = 0.
  - alu_a, alu_b and alu_op are 0 outside EXEC and MUL_STEP.
  - cmd_ready = 1 as soon as rst deasserts.
- States: IDLE, EXEC, MUL_STEP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch a_r, b_r and code.
  - Single op or reserved command -> EXEC.
  - MUL (SUPPORT_MUL = 1): hi = 0, lo = cmd_b, mcand = cmd_a, cnt = 0 -> MUL_STEP.
- EXEC (1 cycle):
  - Single op: drive alu_op = code[2:0], alu_a = a_r, alu_b = b_r.
  - Register res_lo = alu_result, res_hi = 0.
  - Update flags from alu_zero, alu_carry and alu_negative -> DONE.
  - Reserved: res_lo = res_hi = 0, res_err = 1, flags unchanged.
- MUL_STEP (exactly 8 cycles):
  - Drive alu_op = ADD, alu_a = hi, alu_b = lo[0] ? mcand : 0.
  - Next hi = {alu_carry, alu_result[7:1]}.
  - Next lo = {alu_result[0], lo[7:1]}.
  - cnt increments each cycle; when cnt == 7 -> DONE.
- On MUL completion:
  - res_hi = final hi, res_lo = final lo.
  - flag_z = (product == 0).
  - flag_c = (hi != 0), i.e. the product does not fit in 8 bits.
  - flag_n = hi[7].
- DONE:
  - res_valid = 1; res_hi, res_lo, res_err and flags are held stable.
  - On res_ready -> IDLE, and res_valid drops the next cycle.
  - cmd_ready = 0, and cmd_valid is ignored.
- Latency, counted from the cmd accept edge (cycle 0):
  - Single op: res_valid high in cycle 2.
  - MUL: res_valid high in cycle 9.
  - Minimum command-to-command interval: 3 cycles (single op) and 10 cycles (MUL).
- Flags change only on the EXEC -> DONE or MUL_STEP -> DONE transition. SUB carry is the ALU borrow, passed through unmodified.
- flush:
  - In EXEC, MUL_STEP or DONE: go to IDLE next cycle, no res_valid, flags unchanged.
  - flush beats a simultaneous res_ready; the result is dropped.
  - In IDLE: flush blocks acceptance that cycle.
- rst asserted mid-operation: immediate return to the reset state; no partial result is ever presented.

Decomposition:
- Shared package mak8_pkg holds:
  - alu_op_t enum (ADD = 0 .. SHR = 7), shared with the ALU.
  - Command encodings CMD_MUL = 4'b1000 and the CMD_SINGLE prefix.
  - seq_state_t enum.
- No sub-module. The ALU is instantiated by the parent and connected through the alu_* ports, so the ALU stays shareable.

Test Plan:
- Reset: assert rst during MUL step 3 -> all outputs 0 immediately; cmd_ready = 1 the first cycle after release; flags 0.
- ADD a=0xF0, b=0x20 -> res_lo = 0x10, res_hi = 0, C = 1, Z = 0, N = 0; res_valid in cycle 2. SUB a=0x05, b=0x05 -> res_lo = 0x00, Z = 1, C = 0.
- MUL 0xFF x 0xFF -> res_hi = 0xFE, res_lo = 0x01, C = 1, N = 1, Z = 0; res_valid in cycle 9; alu_op = ADD for all 8 step cycles.
- MUL 0x00 x 0x37 -> 0x0000, Z = 1, C = 0, N = 0; MUL 0x0C x 0x0A -> 0x0078, C = 0.
- Backpressure: hold res_ready = 0 for 5 cycles with cmd_valid = 1 -> outputs stable, cmd_ready = 0, no extra command accepted; accept fires on the first res_ready.
- flush in MUL step 4 -> IDLE next cycle, no res_valid, flags retain the previous values. Reserved code 4'b1011 -> res_err = 1, result 0x0000, flags unchanged.
